// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: PC handshake, instruction memory port, decode-side IR port.
interface fetch_unit_if #(parameter int INSTR_W = 16);
   logic [11:0]        PC_in;
   logic               PC_Write;
   logic               imem_req;
   logic [11:0]        imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_data;
   logic [INSTR_W-1:0] IR_out;
   logic [11:0]        IR_pc;
   logic               IR_valid;
   logic               IR_ready;
   logic               flush;
   logic               fetch_err;

   modport master (
      input  PC_in, imem_ack, imem_data, IR_ready, flush,
      output PC_Write, imem_req, imem_addr, IR_out, IR_pc, IR_valid, fetch_err
   );
   modport slave (
      output PC_in, imem_ack, imem_data, IR_ready, flush,
      input  PC_Write, imem_req, imem_addr, IR_out, IR_pc, IR_valid, fetch_err
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (IDLE/REQ/HOLD) with flush discard handling.
// Optional REQ wait timeout with sticky fetch_err: define FETCH_TIMEOUT_EN.
module fetch_unit #(
   parameter int INSTR_W = 16,
   parameter int TIMEOUT = 15
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t state, state_nxt;
   logic   discard;
   logic   ack_ok;
   logic   timeout_hit;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fetch_unit: TIMEOUT must be at least 1");
   end

   // An ack is only usable if no redirect happened during or before it.
   assign ack_ok       = bus.imem_ack && !discard && !bus.flush;
   assign bus.PC_Write = (state == REQ) && ack_ok;
   assign bus.imem_req = (state == REQ);
   assign bus.IR_valid = (state == HOLD);

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   assign timeout_hit   = (state == REQ) && !bus.imem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
   assign bus.fetch_err = err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == REQ && !bus.imem_ack && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
         else                                               wait_cnt <= '0;
         if (timeout_hit) err_q <= 1'b1;
      end
   end
`else
   assign timeout_hit   = 1'b0;
   assign bus.fetch_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            if (bus.imem_ack)     state_nxt = ack_ok ? HOLD : IDLE;
            else if (timeout_hit) state_nxt = IDLE;
         end
         HOLD: begin
            if (bus.flush)         state_nxt = IDLE;
            else if (bus.IR_ready) state_nxt = REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.imem_addr <= '0;
         bus.IR_out    <= {INSTR_W{1'b0}};
         bus.IR_pc     <= '0;
         discard       <= 1'b0;
      end else begin
         // PC_in has already advanced by the time HOLD hands off, so no bubble.
         if (state == IDLE || (state == HOLD && bus.IR_ready && !bus.flush))
            bus.imem_addr <= bus.PC_in;
         if (state == REQ) begin
            if (bus.imem_ack || timeout_hit) discard <= 1'b0;
            else if (bus.flush)              discard <= 1'b1;
            if (ack_ok) begin
               bus.IR_out <= bus.imem_data;
               bus.IR_pc  <= bus.imem_addr;
            end
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an IR scoreboard checked at each decode transfer.
module tb_fetch_unit;
   logic clk;
   logic reset;
   int   n_cmp  = 0;
   int   n_err  = 0;
   int   n_xfer = 0;
   int   n_push = 0;
   int   n_pcw  = 0;
   int   cyc    = 0;

   typedef struct {
      logic [11:0] pc;
      logic [15:0] ins;
   } exp_t;
   exp_t sb[$];

   fetch_unit_if #(.INSTR_W(16)) bus ();

   fetch_unit #(.INSTR_W(16), .TIMEOUT(15)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transfer monitor: pops the scoreboard whenever decode accepts IR_out.
   always @(negedge clk) begin
      #4;
      if (reset === 1'b1 && bus.PC_Write === 1'b1) n_pcw++;
      if (reset === 1'b1 && bus.IR_valid === 1'b1 && bus.IR_ready === 1'b1 && bus.flush === 1'b0) begin
         n_xfer++;
         chk("sb_nonempty", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("xfer_IR_out", bus.IR_out, e.ins);
            chk("xfer_IR_pc", bus.IR_pc, e.pc);
         end
      end
   end

   task automatic wait_req();
      repeat (20) begin
         if (bus.imem_req === 1'b1) break;
         @(negedge clk); #1;
      end
      chk("wait_req", bus.imem_req, 1);
   endtask

   // Acks on the lat-th REQ cycle; returns at negedge+1 of the first HOLD cycle.
   task automatic do_fetch(input int lat, input logic [15:0] data, input logic [11:0] addr,
                           input bit keep, output int ack_cyc);
      exp_t e;
      wait_req();
      chk("req_addr", bus.imem_addr, addr);
      for (int i = 1; i < lat; i++) begin
         @(negedge clk); #1;
         chk("wait_req_hi", bus.imem_req, 1);
         chk("wait_addr", bus.imem_addr, addr);
         chk("wait_pcw", bus.PC_Write, 0);
      end
      bus.imem_ack  = 1'b1;
      bus.imem_data = data;
      ack_cyc = cyc;
      #1;
      chk("ack_pcw", bus.PC_Write, 1);
      if (keep) begin
         e.pc = addr; e.ins = data;
         sb.push_back(e);
         n_push++;
      end
      bus.PC_in = addr + 12'd1;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      #1;
      chk("hold_valid", bus.IR_valid, 1);
      chk("hold_req", bus.imem_req, 0);
      chk("hold_IR_out", bus.IR_out, data);
      chk("hold_IR_pc", bus.IR_pc, addr);
   endtask

   initial begin
      int t0, t1, t2, p0;
      reset         = 1'b1;
      bus.PC_in     = 12'h123;
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'hFFFF;
      bus.IR_ready  = 1'b0;
      bus.flush     = 1'b0;
      #2 reset = 1'b0;
      #2;
      // reset is asynchronous: checked before any clock edge
      chk("rst_valid", bus.IR_valid, 0);
      chk("rst_req", bus.imem_req, 0);
      chk("rst_addr", bus.imem_addr, 0);
      chk("rst_IR_out", bus.IR_out, 0);
      chk("rst_IR_pc", bus.IR_pc, 0);
      chk("rst_err", bus.fetch_err, 0);
      chk("rst_pcw", bus.PC_Write, 0);
      repeat (2) @(negedge clk);
      #1 chk("rst_hold_req", bus.imem_req, 0);

      // zero-wait stream from PC 0
      @(negedge clk);
      reset        = 1'b1;
      bus.imem_ack = 1'b0;
      bus.PC_in    = 12'h000;
      bus.IR_ready = 1'b1;
      #1;
      do_fetch(1, 16'h1000, 12'h000, 1, t0);
      do_fetch(1, 16'h1001, 12'h001, 1, t1);
      do_fetch(1, 16'h1002, 12'h002, 1, t2);
      chk("issue_gap_01", t1 - t0, 2);
      chk("issue_gap_12", t2 - t1, 2);

      // 3-cycle ack latency, then 5 stall cycles in HOLD
      @(negedge clk);
      bus.IR_ready = 1'b0;
      #1;
      p0 = n_pcw;
      do_fetch(3, 16'hA5C3, 12'h003, 1, t0);
      repeat (5) begin
         chk("stall_valid", bus.IR_valid, 1);
         chk("stall_req", bus.imem_req, 0);
         chk("stall_IR_out", bus.IR_out, 16'hA5C3);
         chk("stall_pcw", bus.PC_Write, 0);
         @(negedge clk); #1;
      end
      chk("lat3_pcw_pulses", n_pcw - p0, 1);
      bus.IR_ready = 1'b1;

      // flush in first cycle of a slow REQ: the late ack must be dropped
      @(negedge clk);
      bus.IR_ready = 1'b0;
      #1;
      wait_req();
      chk("fl_req_addr", bus.imem_addr, 12'h004);
      bus.flush = 1'b1;
      bus.PC_in = 12'h200;
      #1 chk("fl_pcw0", bus.PC_Write, 0);
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      chk("fl_req_kept", bus.imem_req, 1);
      chk("fl_addr_kept", bus.imem_addr, 12'h004);
      @(negedge clk);
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'hDEAD;
      #1 chk("fl_ack_pcw", bus.PC_Write, 0);
      @(negedge clk);
      bus.imem_ack = 1'b0;
      #1;
      chk("fl_valid", bus.IR_valid, 0);
      chk("fl_idle_req", bus.imem_req, 0);
      chk("fl_IR_out_kept", bus.IR_out, 16'hA5C3);
      chk("fl_IR_pc_kept", bus.IR_pc, 12'h003);
      do_fetch(1, 16'h5A5A, 12'h200, 0, t0);

      // flush beats IR_ready in HOLD; flush held through IDLE is harmless
      bus.flush    = 1'b1;
      bus.IR_ready = 1'b1;
      bus.PC_in    = 12'h300;
      #1 chk("hf_valid_now", bus.IR_valid, 1);
      @(negedge clk); #1;
      chk("hf_valid_next", bus.IR_valid, 0);
      chk("hf_idle_req", bus.imem_req, 0);
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      chk("hf_req", bus.imem_req, 1);
      chk("hf_addr", bus.imem_addr, 12'h300);
      do_fetch(1, 16'hC0DE, 12'h300, 1, t0);

      // flush and ack in the same REQ cycle
      @(negedge clk); #1;
      wait_req();
      chk("fa_addr", bus.imem_addr, 12'h301);
      bus.flush     = 1'b1;
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'hBEEF;
      #1 chk("fa_pcw", bus.PC_Write, 0);
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.imem_ack = 1'b0;
      bus.PC_in    = 12'h400;
      #1;
      chk("fa_valid", bus.IR_valid, 0);
      chk("fa_req", bus.imem_req, 0);
      chk("fa_IR_pc", bus.IR_pc, 12'h300);
      chk("fa_IR_out", bus.IR_out, 16'hC0DE);

      // reset mid-REQ, late ack after release
      @(negedge clk); #1;
      wait_req();
      chk("rr_addr", bus.imem_addr, 12'h400);
      reset        = 1'b0;
      bus.imem_ack = 1'b1;
      #1;
      chk("rr_req", bus.imem_req, 0);
      chk("rr_pcw", bus.PC_Write, 0);
      chk("rr_addr0", bus.imem_addr, 0);
      chk("rr_IR_out0", bus.IR_out, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rr_late_pcw", bus.PC_Write, 0);
      chk("rr_late_req", bus.imem_req, 0);
      @(negedge clk);
      bus.imem_ack = 1'b0;
      #1;
      chk("rr_restart_req", bus.imem_req, 1);
      chk("rr_restart_addr", bus.imem_addr, 12'h400);
      chk("rr_restart_valid", bus.IR_valid, 0);

`ifdef FETCH_TIMEOUT_EN
      repeat (14) begin
         @(negedge clk); #1;
      end
      chk("to_req_c15", bus.imem_req, 1);
      chk("to_err_c15", bus.fetch_err, 0);
      @(negedge clk); #1;
      chk("to_req_drop", bus.imem_req, 0);
      chk("to_err_set", bus.fetch_err, 1);
      repeat (4) @(negedge clk);
      #1 chk("to_err_sticky", bus.fetch_err, 1);
      reset = 1'b0;
      #1 chk("to_err_clr", bus.fetch_err, 0);
      @(negedge clk);
      reset = 1'b1;
`else
      repeat (20) @(negedge clk);
      #1;
      chk("nt_req_wait", bus.imem_req, 1);
      chk("nt_addr_wait", bus.imem_addr, 12'h400);
      chk("nt_err", bus.fetch_err, 0);
      do_fetch(1, 16'h1234, 12'h400, 1, t0);
`endif

      repeat (2) @(negedge clk);
      #5;
      chk("sb_drained", sb.size(), 0);
      chk("xfer_count", n_xfer, n_push);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #20000;
      n_err++;
      $display("FAIL watchdog: observed time %0t expected finish", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end
endmodule
